// File: rtl/proc_run_ctrl_if.sv
// Control/status bundle between the run controller and its host.
//   master: host side, drives start/step/stop and forwards the core's inst_word.
//   slave : controller side, drives proc_reset/proc_en and the status outputs.
// Signals:
//   start, step, stop  single-cycle command pulses
//   inst_word          instruction word currently fetched by the core
//   proc_reset         reset to the core
//   proc_en            clock-enable to the core
//   busy, halted       run status
//   timeout            sticky watchdog flag
//   cycle_count        number of enabled cycles since the last (re)start
interface proc_run_ctrl_if #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned CNT_BITS = 32
);
    logic                start;
    logic                step;
    logic                stop;
    logic [DBITS-1:0]    inst_word;
    logic                proc_reset;
    logic                proc_en;
    logic                busy;
    logic                halted;
    logic                timeout;
    logic [CNT_BITS-1:0] cycle_count;

    modport master (
        output start, step, stop, inst_word,
        input  proc_reset, proc_en, busy, halted, timeout, cycle_count
    );

    modport slave (
        input  start, step, stop, inst_word,
        output proc_reset, proc_en, busy, halted, timeout, cycle_count
    );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run/sequencing controller for the single-cycle processor core.
// Drives the core's reset and clock-enable from start/step/stop commands, stops the core a
// fixed number of enabled cycles after it fetches HALT_WORD, and counts enabled cycles.
// Ports:
//   clk    system clock
//   reset  synchronous active-high controller reset
//   bus    proc_run_ctrl_if.slave (commands, inst_word in; core controls and status out)
// All bus outputs are registered decodes of the next state, so they line up with state_q.
// Optional: define PROC_RUN_CTRL_WATCHDOG_EN to force HALTED with timeout=1 after WDT_CYCLES
// consecutive RUN/DRAIN cycles; otherwise timeout is tied low.
module proc_run_ctrl #(
    parameter int unsigned      DBITS        = 32,
    parameter logic [DBITS-1:0] HALT_WORD    = DBITS'(32'h0000DEAD),
    parameter int unsigned      RST_CYCLES   = 2,
    parameter int unsigned      DRAIN_CYCLES = 2,
    parameter int unsigned      CNT_BITS     = 32,
    parameter int unsigned      WDT_CYCLES   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    proc_run_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        StIdle, StReset, StRun, StPaused, StStep, StDrain, StHalted
    } state_e;

    localparam logic [3:0] RcLast = 4'(RST_CYCLES - 1);
    localparam logic [3:0] DcLast = 4'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam state_e     HaltTarget = (DRAIN_CYCLES == 0) ? StHalted : StDrain;

    state_e              state_q, state_d;
    logic [3:0]          rc_q, rc_d;
    logic [3:0]          dc_q, dc_d;
    logic [CNT_BITS-1:0] cycle_count_q, cycle_count_d;
    logic                proc_reset_q, proc_en_q, busy_q, halted_q;
    logic                cmd_stop, cmd_step, cmd_start;
    logic                halt_det;
    logic                restart;

`ifdef PROC_RUN_CTRL_WATCHDOG_EN
    localparam int unsigned WdtW    = $clog2(WDT_CYCLES + 1);
    localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);
    logic [WdtW-1:0] wdt_q, wdt_d;
    logic            timeout_q, timeout_d;
`endif

    // Simultaneous commands resolve as stop > step > start.
    assign cmd_stop  = bus.stop;
    assign cmd_step  = bus.step & ~bus.stop;
    assign cmd_start = bus.start & ~bus.step & ~bus.stop;

    // The fetched word only matters while the core is actually advancing.
    assign halt_det = ((state_q == StRun) || (state_q == StStep)) && (bus.inst_word == HALT_WORD);

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        dc_d    = dc_q;
        restart = 1'b0;

        unique case (state_q)
            StIdle, StHalted: begin
                if (cmd_start) begin
                    state_d = StReset;
                    rc_d    = '0;
                    restart = 1'b1;
                end
            end
            StReset: begin
                if (rc_q == RcLast) state_d = StRun;
                else                rc_d    = rc_q + 4'd1;
            end
            StRun: begin
                // Halt wins over a same-cycle stop.
                if (halt_det) begin
                    state_d = HaltTarget;
                    dc_d    = '0;
                end else if (cmd_stop) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (cmd_step)       state_d = StStep;
                else if (cmd_start) state_d = StRun;
            end
            StStep: begin
                if (halt_det) begin
                    state_d = HaltTarget;
                    dc_d    = '0;
                end else begin
                    state_d = StPaused;
                end
            end
            StDrain: begin
                if (dc_q == DcLast) state_d = StHalted;
                else                dc_d    = dc_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase

        // Counts completed enabled cycles; proc_en_q is the enable of the cycle now ending.
        cycle_count_d = restart ? '0 : cycle_count_q + CNT_BITS'(proc_en_q);

`ifdef PROC_RUN_CTRL_WATCHDOG_EN
        wdt_d     = wdt_q;
        timeout_d = restart ? 1'b0 : timeout_q;
        if ((state_q == StRun) || (state_q == StDrain)) begin
            if (wdt_q == WdtLast) begin
                state_d   = StHalted;
                timeout_d = 1'b1;
            end else begin
                wdt_d = wdt_q + 1'b1;
            end
        end
        // Entry into RUN (from RESET or a resume from PAUSED) starts a fresh window.
        if ((state_d == StRun) && (state_q != StRun)) wdt_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rc_q          <= '0;
            dc_q          <= '0;
            cycle_count_q <= '0;
            proc_reset_q  <= 1'b1;
            proc_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            dc_q          <= dc_d;
            cycle_count_q <= cycle_count_d;
            proc_reset_q  <= (state_d == StIdle) || (state_d == StReset);
            proc_en_q     <= (state_d == StRun) || (state_d == StStep) || (state_d == StDrain);
            busy_q        <= (state_d == StReset) || (state_d == StRun) ||
                             (state_d == StStep) || (state_d == StDrain);
            halted_q      <= (state_d == StHalted);
        end
    end

`ifdef PROC_RUN_CTRL_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdt_q     <= wdt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.proc_reset  = proc_reset_q;
    assign bus.proc_en     = proc_en_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: each step drives commands, queues the expected state of the
// outputs after the next edge, then pops and checks that expectation 1 ns after the edge.
module tb_proc_run_ctrl;
    localparam int unsigned DBITS    = 32;
    localparam int unsigned CNT_BITS = 32;
    localparam logic [31:0] HW       = 32'h0000DEAD;

    // Expected {proc_reset, proc_en, busy, halted, timeout} per state.
    localparam logic [4:0] C_IDLE  = 5'b10000;
    localparam logic [4:0] C_RST   = 5'b10100;
    localparam logic [4:0] C_EN    = 5'b01100;
    localparam logic [4:0] C_PAUSE = 5'b00000;
    localparam logic [4:0] C_HALT  = 5'b00010;
    localparam logic [4:0] C_TMO   = 5'b00011;

    typedef struct {
        string       tag;
        logic [4:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    proc_run_ctrl_if #(.DBITS(DBITS), .CNT_BITS(CNT_BITS)) bus ();

    proc_run_ctrl #(
        .DBITS       (DBITS),
        .HALT_WORD   (HW),
        .RST_CYCLES  (2),
        .DRAIN_CYCLES(2),
        .CNT_BITS    (CNT_BITS),
        .WDT_CYCLES  (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic i_start, input logic i_step, input logic i_stop,
                       input logic [31:0] iw, input string tag,
                       input logic [4:0] ctl, input logic [31:0] cnt);
        exp_t e;
        exp_t g;
        logic [4:0] obs;
        bus.start     = i_start;
        bus.step      = i_step;
        bus.stop      = i_stop;
        bus.inst_word = iw;
        e.tag = tag;
        e.ctl = ctl;
        e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        bus.stop  = 1'b0;
        g   = sb.pop_front();
        obs = {bus.proc_reset, bus.proc_en, bus.busy, bus.halted, bus.timeout};
        total++;
        assert (obs === g.ctl) else begin
            bad++;
            $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
        end
        total++;
        assert (bus.cycle_count === g.cnt) else begin
            bad++;
            $error("FAIL %s count observed=%0d expected=%0d", g.tag, bus.cycle_count, g.cnt);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.stop      = 1'b0;
        bus.inst_word = '0;
        reset         = 1'b1;

        cyc(0, 0, 0, 0, "reset0", C_IDLE, 0);
        cyc(0, 0, 0, 0, "reset1", C_IDLE, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, "idle", C_IDLE, 0);

        // Start: two RESET cycles then RUN with count 0,1,2,...
        cyc(1, 0, 0, 0, "start_rst1", C_RST, 0);
        cyc(0, 0, 0, 0, "start_rst2", C_RST, 0);
        cyc(0, 0, 0, 0, "run_first", C_EN, 0);
        for (int i = 1; i <= 10; i++) cyc(0, 0, 0, 0, "run_cnt", C_EN, i);

        // Halt word at count 10: two drain cycles, then frozen at 13.
        cyc(0, 0, 0, HW, "halt_drain1", C_EN, 11);
        cyc(0, 0, 0, 0, "halt_drain2", C_EN, 12);
        cyc(0, 0, 0, 0, "halted", C_HALT, 13);
        cyc(0, 0, 0, HW, "halted_hold", C_HALT, 13);

        // Restart from HALTED clears the count.
        cyc(1, 0, 0, 0, "restart_rst1", C_RST, 0);
        cyc(0, 0, 0, 0, "restart_rst2", C_RST, 0);
        cyc(0, 0, 0, 0, "restart_run", C_EN, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, "run2_cnt", C_EN, i);

        // Stop, hold, halt word ignored while paused, then three single steps.
        cyc(0, 0, 1, 0, "stop", C_PAUSE, 5);
        cyc(0, 0, 0, 0, "paused_hold", C_PAUSE, 5);
        cyc(0, 0, 0, HW, "paused_ignore_hw", C_PAUSE, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, "step_pulse", C_EN, 5 + i);
            cyc(0, 0, 0, 0, "step_back", C_PAUSE, 6 + i);
        end

        // Resume runs without a core reset.
        cyc(1, 0, 0, 0, "resume", C_EN, 8);
        cyc(0, 0, 0, 0, "resume_run", C_EN, 9);

        // stop beats start in RUN.
        cyc(1, 0, 1, 0, "stop_start", C_PAUSE, 10);
        cyc(1, 0, 0, 0, "resume2", C_EN, 10);
        cyc(0, 0, 0, 0, "resume2_run", C_EN, 11);

        // Halt beats stop; stop ignored in DRAIN; reset during DRAIN.
        cyc(0, 0, 1, HW, "halt_stop", C_EN, 12);
        cyc(0, 0, 1, 0, "drain_stop_ign", C_EN, 13);
        reset = 1'b1;
        cyc(0, 0, 0, 0, "reset_in_drain", C_IDLE, 0);
        reset = 1'b0;
        cyc(0, 1, 0, 0, "idle_step_ign", C_IDLE, 0);
        cyc(0, 0, 1, 0, "idle_stop_ign", C_IDLE, 0);

        // Halt fetched during a single step.
        cyc(1, 0, 0, 0, "s_rst1", C_RST, 0);
        cyc(0, 0, 0, 0, "s_rst2", C_RST, 0);
        cyc(0, 0, 0, 0, "s_run", C_EN, 0);
        cyc(0, 0, 1, 0, "s_stop", C_PAUSE, 1);
        cyc(0, 1, 0, 0, "s_step", C_EN, 1);
        cyc(0, 0, 0, HW, "s_step_halt", C_EN, 2);
        cyc(0, 0, 0, 0, "s_drain2", C_EN, 3);
        cyc(0, 0, 0, 0, "s_halted", C_HALT, 4);

        // Long run without a halt word.
        cyc(1, 0, 0, 0, "w_rst1", C_RST, 0);
        cyc(0, 0, 0, 0, "w_rst2", C_RST, 0);
        cyc(0, 0, 0, 0, "w_run", C_EN, 0);
        for (int i = 1; i <= 30; i++) begin
`ifdef PROC_RUN_CTRL_WATCHDOG_EN
            if (i < 20) cyc(0, 0, 0, 0, "wdt_run", C_EN, i);
            else        cyc(0, 0, 0, 0, "wdt_fired", C_TMO, 20);
`else
            cyc(0, 0, 0, 0, "no_wdt_run", C_EN, i);
`endif
        end
`ifdef PROC_RUN_CTRL_WATCHDOG_EN
        cyc(1, 0, 0, 0, "wdt_restart_clr", C_RST, 0);
`else
        cyc(0, 0, 1, 0, "no_wdt_stop", C_PAUSE, 31);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
